expr_eval: RTL and testbench

Downstream consumer of the character-stream recognizer: evaluates the same byte stream (one ASCII character per accepted cycle) as an expression of single decimal digits joined by `+` and `*`, with `*` binding tighter than `+`. The recognizer answers "is the prefix well-formed"; this block produces the numeric value of the prefix consumed so far. It also raises a sticky error and a sticky overflow indication. Intended to sit beside the recognizer on the same input bus and clock.

---
 rtl/expr_eval_if.sv | 30 +++
 rtl/expr_eval.sv | 132 +++++++++++++
 tb/tb_expr_eval.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/expr_eval_if.sv
// Character bus between a stream source and expr_eval: one ASCII byte per
// qualified cycle in, evaluated value and status flags out.
interface expr_eval_if #(
  parameter int W = 16
);
  logic [7:0]   in;
  logic         in_vld;
  logic [W-1:0] value;
  logic         ok;
  logic         err;
  logic         ovf;

  modport master (
    output in,
    output in_vld,
    input  value,
    input  ok,
    input  err,
    input  ovf
  );

  modport slave (
    input  in,
    input  in_vld,
    output value,
    output ok,
    output err,
    output ovf
  );
endinterface

// File: rtl/expr_eval.sv
// Evaluates a stream of single digits joined by '+' and '*' ('*' binds tighter).
// Optional clamping arithmetic is enabled by defining EXPR_SAT_EN.
module expr_eval #(
  parameter int W = 16
) (
  input logic        clk,
  input logic        clr,
  expr_eval_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIG  = 3'd1,
    OPA  = 3'd2,
    OPM  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int XW = W + 4;
  localparam logic [XW-1:0] MAX_X = {4'h0, {W{1'b1}}};

  // Narrow a wide intermediate back to W bits: clamp or wrap depending on build.
  function automatic logic [W-1:0] fit(input logic [XW-1:0] x);
`ifdef EXPR_SAT_EN
    fit = (x > MAX_X) ? {W{1'b1}} : x[W-1:0];
`else
    fit = x[W-1:0];
`endif
  endfunction

  state_t        state_r;
  state_t        state_n_s;
  logic [W-1:0]  s_r;
  logic [W-1:0]  p_r;
  logic          ovf_r;
  logic [W-1:0]  s_n_s;
  logic [W-1:0]  p_n_s;
  logic          ovf_n_s;
  logic          is_dig_s;
  logic [W-1:0]  digit_s;
  logic [XW-1:0] prod_x_s;
  logic [XW-1:0] sum_x_s;
  logic [XW-1:0] show_n_x_s;
  logic [XW-1:0] show_x_s;

  assign is_dig_s   = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign digit_s    = {{(W-4){1'b0}}, bus.in[3:0]};
  assign prod_x_s   = {4'h0, p_r} * {{(XW-4){1'b0}}, bus.in[3:0]};
  assign sum_x_s    = {4'h0, s_r} + {4'h0, p_r};
  assign show_n_x_s = {4'h0, s_n_s} + {4'h0, p_n_s};
  assign show_x_s   = {4'h0, s_r} + {4'h0, p_r};

  // Next-state, next-operand and overflow computation for one accepted character.
  always_comb begin
    state_n_s = state_r;
    s_n_s     = s_r;
    p_n_s     = p_r;
    ovf_n_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (is_dig_s) begin
          p_n_s     = digit_s;
          s_n_s     = {W{1'b0}};
          state_n_s = DIG;
        end else begin
          state_n_s = ERR;
        end
      end
      DIG: begin
        if (bus.in == 8'h2B) begin
          s_n_s     = fit(sum_x_s);
          ovf_n_s   = ovf_r | (sum_x_s > MAX_X);
          state_n_s = OPA;
        end else if (bus.in == 8'h2A) begin
          state_n_s = OPM;
        end else begin
          state_n_s = ERR;
        end
      end
      OPA: begin
        if (is_dig_s) begin
          p_n_s     = digit_s;
          state_n_s = DIG;
        end else begin
          state_n_s = ERR;
        end
      end
      OPM: begin
        if (is_dig_s) begin
          p_n_s     = fit(prod_x_s);
          ovf_n_s   = ovf_r | (prod_x_s > MAX_X);
          state_n_s = DIG;
        end else begin
          state_n_s = ERR;
        end
      end
      ERR: begin
        state_n_s = ERR;
      end
      default: begin
        state_n_s = ERR;
      end
    endcase
    // The displayed sum counts as arithmetic too, flagged at the edge that forms it.
    if ((state_n_s == DIG) && (show_n_x_s > MAX_X)) begin
      ovf_n_s = 1'b1;
    end else begin
      ovf_n_s = ovf_n_s;
    end
  end

  // State and datapath registers; clr wins over a character in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      s_r     <= {W{1'b0}};
      p_r     <= {W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (bus.in_vld) begin
      state_r <= state_n_s;
      s_r     <= s_n_s;
      p_r     <= p_n_s;
      ovf_r   <= ovf_n_s;
    end
  end

  assign bus.value = (state_r == DIG) ? fit(show_x_s) : {W{1'b0}};
  assign bus.ok    = (state_r == DIG);
  assign bus.err   = (state_r == ERR);
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_expr_eval.sv
// Table-driven scoreboard bench for expr_eval at W=8; expectations follow
// EXPR_SAT_EN so the same bench covers both builds.
module tb_expr_eval;

  localparam int W = 8;
`ifdef EXPR_SAT_EN
  localparam logic [7:0] V729 = 8'd255;
  localparam logic [7:0] V324 = 8'd255;
  localparam logic [7:0] V486 = 8'd255;
`else
  localparam logic [7:0] V729 = 8'd217;
  localparam logic [7:0] V324 = 8'd68;
  localparam logic [7:0] V486 = 8'd230;
`endif

  typedef struct {
    logic [7:0] ch;
    logic       vld;
    logic       clr;
    logic       ok;
    logic [7:0] value;
    logic       err;
    logic       ovf;
    string      name;
  } vec_t;

  logic clk;
  logic clr;
  expr_eval_if #(.W(W)) bus ();

  expr_eval #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic [7:0] ch, input logic vld, input logic c,
                              input logic ok, input logic [7:0] value,
                              input logic err, input logic ovf, input string name);
    vec_t v;
    v.ch = ch; v.vld = vld; v.clr = c; v.ok = ok; v.value = value;
    v.err = err; v.ovf = ovf; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, push its expectation, then pop and compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    bus.in     = v.ch;
    bus.in_vld = v.vld;
    clr        = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".ok"},    {15'd0, bus.ok},  {15'd0, e.ok});
      chk({e.name, ".value"}, {8'd0, bus.value}, {8'd0, e.value});
      chk({e.name, ".err"},   {15'd0, bus.err}, {15'd0, e.err});
      chk({e.name, ".ovf"},   {15'd0, bus.ovf}, {15'd0, e.ovf});
    end
  endtask

  task automatic run1(input logic [7:0] ch, input logic vld, input logic c,
                      input logic ok, input logic [7:0] value,
                      input logic err, input logic ovf, input string name);
    vec_t v;
    v.ch = ch; v.vld = vld; v.clr = c; v.ok = ok; v.value = value;
    v.err = err; v.ovf = ovf; v.name = name;
    step(v);
  endtask

  initial begin
    bus.in     = 8'h00;
    bus.in_vld = 1'b0;
    clr        = 1'b0;

    //   ch     vld   clr   ok    value  err   ovf
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "reset");
    add("1",   1'b1, 1'b0, 1'b1, 8'd1,  1'b0, 1'b0, "p1_1");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p1_plus");
    add("2",   1'b1, 1'b0, 1'b1, 8'd3,  1'b0, 1'b0, "p1_2");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p1_mul");
    add("3",   1'b1, 1'b0, 1'b1, 8'd7,  1'b0, 1'b0, "p1_3");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr2");
    add("2",   1'b1, 1'b0, 1'b1, 8'd2,  1'b0, 1'b0, "p2_2");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_mul");
    add("3",   1'b1, 1'b0, 1'b1, 8'd6,  1'b0, 1'b0, "p2_3");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_mul2");
    add("9",   1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_gap1");
    add("+",   1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_gap2");
    add("x",   1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_gap3");
    add("4",   1'b1, 1'b0, 1'b1, 8'd24, 1'b0, 1'b0, "p2_4");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p2_plus");
    add("5",   1'b1, 1'b0, 1'b1, 8'd29, 1'b0, 1'b0, "p2_5");
    add("+",   1'b0, 1'b0, 1'b1, 8'd29, 1'b0, 1'b0, "p2_hold");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr3");
    add("1",   1'b1, 1'b0, 1'b1, 8'd1,  1'b0, 1'b0, "p3_1");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p3_plus");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p3_plus2");
    add("3",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p3_3");
    add("3",   1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "p3_clr");
    add("8",   1'b1, 1'b0, 1'b1, 8'd8,  1'b0, 1'b0, "p3_8");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr4");
    add("9",   1'b1, 1'b0, 1'b1, 8'd9,  1'b0, 1'b0, "p4_9");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p4_mul");
    add("9",   1'b1, 1'b0, 1'b1, 8'd81, 1'b0, 1'b0, "p4_81");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p4_mul2");
    add("9",   1'b1, 1'b0, 1'b1, V729,  1'b0, 1'b1, "p4_729");
    add("7",   1'b0, 1'b0, 1'b1, V729,  1'b0, 1'b1, "p4_hold");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr5");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p5_plus");
    add("4",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p5_4");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr6");
    add("9",   1'b1, 1'b0, 1'b1, 8'd9,  1'b0, 1'b0, "p6_9");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p6_mul");
    add("9",   1'b1, 1'b0, 1'b1, 8'd81, 1'b0, 1'b0, "p6_81");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p6_mul2");
    add("3",   1'b1, 1'b0, 1'b1, 8'd243,1'b0, 1'b0, "p6_243");
    add("+",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p6_plus");
    add("9",   1'b1, 1'b0, 1'b1, 8'd252,1'b0, 1'b0, "p6_252");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "p6_mul3");
    add("9",   1'b1, 1'b0, 1'b1, V324,  1'b0, 1'b1, "p6_324");
    add("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, "p6_mul4");
    add("3",   1'b1, 1'b0, 1'b1, V486,  1'b0, 1'b1, "p6_486");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr7");
    add("7",   1'b1, 1'b0, 1'b1, 8'd7,  1'b0, 1'b0, "p7_7");
    add("7",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p7_digdig");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr8");
    add(" ",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p8_space");
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "clr9");
    add("0",   1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0, "p9_0");
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, "p9_nul");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // clr and a digit in the same cycle: the digit is discarded.
    run1(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "h_clr");
    run1("5",   1'b1, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, "h_5");
    run1("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "h_mul");
    run1("3",   1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "h_clr_and_3");
    run1("3",   1'b1, 1'b0, 1'b1, 8'd3,  1'b0, 1'b0, "h_3");

    // Overflow stays sticky across later well-formed input until clr.
    run1(8'h00, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, "s_clr");
    run1("9",   1'b1, 1'b0, 1'b1, 8'd9,  1'b0, 1'b0, "s_9");
    run1("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "s_mul");
    run1("9",   1'b1, 1'b0, 1'b1, 8'd81, 1'b0, 1'b0, "s_81");
    run1("*",   1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, "s_mul2");
    run1("9",   1'b1, 1'b0, 1'b1, V729,  1'b0, 1'b1, "s_729");
    run1("x",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, "s_err");
    run1("1",   1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, "s_err_hold");

    if (sb.size() != 0) begin
      chk("scoreboard_leftover", 16'(sb.size()), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
